// File: rtl/fp_result_pack.sv
// Output stage of the FP MAC datapath: round, renormalise, saturate/flush and pack into an IEEE-style word.
// Defining FP_PACK_ROUND_EN gives round-to-nearest-even; without it the significand is truncated.
module fp_result_pack #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_sign,
   input  logic [EXP_W+1:0]       in_exponent,
   input  logic [MAN_W+3:0]       in_significand,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   fp_result,
   output logic [4:0]             flags,
   output logic [4:0]             sticky_flags,
   input  logic                   flags_clear
);

   localparam int XW = EXP_W + 3;
   localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
   localparam logic signed [XW-1:0] EXP_ZERO = '0;

   // flag bit positions
   localparam int F_INEXACT   = 0;
   localparam int F_UNDERFLOW = 1;
   localparam int F_OVERFLOW  = 2;
   localparam int F_ZERO      = 3;
   localparam int F_INFINITY  = 4;

   // ---------------- handshake ----------------
   logic w_b_ld;
   logic w_a_ld;
   logic w_out_xfer;

   logic r_a_valid;
   logic r_out_valid;

   assign w_b_ld     = !r_out_valid || out_ready;
   assign w_a_ld     = !r_a_valid || w_b_ld;
   assign w_out_xfer = r_out_valid && out_ready;
   assign in_ready   = w_a_ld;

   // ---------------- stage A: rounding ----------------
   logic [MAN_W+1:0] w_mant_r;
   logic             w_inexact_in;
   logic             w_zero_in;

   assign w_inexact_in = |in_significand[2:0];
   assign w_zero_in    = (in_significand == '0);

`ifdef FP_PACK_ROUND_EN
   logic w_g;
   logic w_r;
   logic w_s;
   logic w_lsb;
   logic w_round_up;

   assign w_g        = in_significand[2];
   assign w_r        = in_significand[1];
   assign w_s        = in_significand[0];
   assign w_lsb      = in_significand[3];
   assign w_round_up = w_g & (w_r | w_s | w_lsb);
   assign w_mant_r   = {1'b0, in_significand[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, w_round_up};
`else
   assign w_mant_r   = {1'b0, in_significand[MAN_W+3:3]};
`endif

   logic             r_a_sign;
   logic [EXP_W+1:0] r_a_exp;
   logic [MAN_W+1:0] r_a_mant;
   logic             r_a_inexact;
   logic             r_a_zero;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_a_valid   <= 1'b0;
         r_a_sign    <= 1'b0;
         r_a_exp     <= '0;
         r_a_mant    <= '0;
         r_a_inexact <= 1'b0;
         r_a_zero    <= 1'b0;
      end else if (w_a_ld) begin
         r_a_valid <= in_valid;
         if (in_valid) begin
            r_a_sign    <= in_sign;
            r_a_exp     <= in_exponent;
            r_a_mant    <= w_mant_r;
            r_a_inexact <= w_inexact_in;
            r_a_zero    <= w_zero_in;
         end
      end
   end

   // ---------------- stage B: normalise and pack ----------------
   // One extra exponent bit so the carry increment can never wrap the sign.
   logic signed [XW-1:0]  w_exp_ext;
   logic signed [XW-1:0]  w_exp_n;
   logic                  w_carry;
   logic [MAN_W-1:0]      w_frac_n;
   logic                  w_ovf;
   logic                  w_unf;
   logic [EXP_W+MAN_W:0]  w_res;
   logic [4:0]            w_flg;

   assign w_carry   = r_a_mant[MAN_W+1];
   assign w_exp_ext = {r_a_exp[EXP_W+1], r_a_exp};
   assign w_exp_n   = w_exp_ext + {{(XW-1){1'b0}}, w_carry};
   assign w_frac_n  = w_carry ? r_a_mant[MAN_W:1] : r_a_mant[MAN_W-1:0];
   assign w_ovf     = (w_exp_n >= EXP_MAX);
   assign w_unf     = (w_exp_n <= EXP_ZERO);

   always_comb begin
      w_res = {r_a_sign, w_exp_n[EXP_W-1:0], w_frac_n};
      w_flg = '0;
      w_flg[F_INEXACT] = r_a_inexact;
      if (r_a_zero) begin
         w_res          = {r_a_sign, {(EXP_W+MAN_W){1'b0}}};
         w_flg          = '0;
         w_flg[F_ZERO]  = 1'b1;
      end else if (w_ovf) begin
         w_res               = {r_a_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_flg               = '0;
         w_flg[F_OVERFLOW]   = 1'b1;
         w_flg[F_INFINITY]   = 1'b1;
         w_flg[F_INEXACT]    = 1'b1;
      end else if (w_unf) begin
         // no subnormal support: anything at or below the minimum exponent flushes
         w_res               = {r_a_sign, {(EXP_W+MAN_W){1'b0}}};
         w_flg               = '0;
         w_flg[F_UNDERFLOW]  = 1'b1;
         w_flg[F_ZERO]       = 1'b1;
         w_flg[F_INEXACT]    = 1'b1;
      end
   end

   logic [EXP_W+MAN_W:0] r_fp_result;
   logic [4:0]           r_flags;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_out_valid <= 1'b0;
         r_fp_result <= '0;
         r_flags     <= '0;
      end else if (w_b_ld) begin
         r_out_valid <= r_a_valid;
         if (r_a_valid) begin
            r_fp_result <= w_res;
            r_flags     <= w_flg;
         end
      end
   end

   // ---------------- sticky flags ----------------
   logic [4:0] r_sticky;
   logic [4:0] w_sticky_next;

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_sticky
         assign w_sticky_next[gi] = flags_clear ? (w_out_xfer & r_flags[gi])
                                                : (r_sticky[gi] | (w_out_xfer & r_flags[gi]));
      end
   endgenerate

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_sticky <= '0;
      end else begin
         r_sticky <= w_sticky_next;
      end
   end

   assign out_valid    = r_out_valid;
   assign fp_result    = r_fp_result;
   assign flags        = r_flags;
   assign sticky_flags = r_sticky;

endmodule

// File: tb/tb_fp_result_pack.sv
// Directed self-checking bench for fp_result_pack (single precision); expectations follow FP_PACK_ROUND_EN.
module tb_fp_result_pack;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   logic                 clock = 1'b0;
   logic                 resetn = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic                 in_sign = 1'b0;
   logic [EXP_W+1:0]     in_exponent = '0;
   logic [MAN_W+3:0]     in_significand = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic [EXP_W+MAN_W:0] fp_result;
   logic [4:0]           flags;
   logic [4:0]           sticky_flags;
   logic                 flags_clear = 1'b0;

   int checks = 0;
   int errors = 0;

   fp_result_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clock          (clock),
      .resetn         (resetn),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_sign        (in_sign),
      .in_exponent    (in_exponent),
      .in_significand (in_significand),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .fp_result      (fp_result),
      .flags          (flags),
      .sticky_flags   (sticky_flags),
      .flags_clear    (flags_clear)
   );

   always #5 clock = ~clock;

   // Sends one beat into an empty pipeline and returns what comes out; lat counts the transfer edge as 1.
   task automatic drive_single(input logic s, input logic [9:0] e, input logic [23:0] m,
                               input logic [2:0] grs, input logic clr,
                               output logic [31:0] res, output logic [4:0] flg, output int lat);
      res = '0;
      flg = '0;
      lat = 99;
      out_ready = 1'b1;
      in_sign = s;
      in_exponent = e;
      in_significand = {m, grs};
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         if (out_valid === 1'b1) begin
            lat = n;
            res = fp_result;
            flg = flags;
            break;
         end
         @(posedge clock); #1;
      end
      flags_clear = clr;
      @(posedge clock); #1;
      flags_clear = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b0 || fp_result !== 32'h0 || flags !== 5'h0 || sticky_flags !== 5'h0) begin
         errors++;
         $display("FAIL reset_state: got valid=%b result=%h flags=%h sticky=%h expected 0/00000000/00/00",
                  out_valid, fp_result, flags, sticky_flags);
      end
      #2 resetn = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      $display("txn reset: valid=%b result=%h in_ready=%b", out_valid, fp_result, in_ready);
   endtask

   task automatic test_exact();
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
      drive_single(1'b0, 10'd127, 24'h800000, 3'b000, 1'b0, res, flg, lat);
      $display("txn exact_one: result=%h flags=%h latency=%0d", res, flg, lat);
      checks++;
      if (res !== 32'h3F800000 || flg !== 5'h00) begin
         errors++;
         $display("FAIL exact_one: got %h/%h expected 3f800000/00", res, flg);
      end
      checks++;
      if (lat != 2) begin
         errors++;
         $display("FAIL exact_latency: got %0d expected 2", lat);
      end
   endtask

   task automatic test_rounding();
      logic [23:0] mv[4];
      logic [2:0]  gv[4];
      logic [31:0] er[4];
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
      mv = '{24'hFFFFFF, 24'h800000, 24'h800000, 24'h800001};
      gv = '{3'b100, 3'b100, 3'b110, 3'b100};
`ifdef FP_PACK_ROUND_EN
      er = '{32'h40000000, 32'h3F800000, 32'h3F800001, 32'h3F800002};
`else
      er = '{32'h3FFFFFFF, 32'h3F800000, 32'h3F800000, 32'h3F800001};
`endif
      for (int i = 0; i < 4; i++) begin
         drive_single(1'b0, 10'd127, mv[i], gv[i], 1'b0, res, flg, lat);
         $display("txn round_%0d: result=%h flags=%h", i, res, flg);
         checks++;
         if (res !== er[i] || flg !== 5'h01) begin
            errors++;
            $display("FAIL round_%0d: got %h/%h expected %h/01", i, res, flg, er[i]);
         end
      end
   endtask

   task automatic test_overflow();
      logic        sv[4];
      logic [9:0]  ev[4];
      logic [23:0] mv[4];
      logic [2:0]  gv[4];
      logic [31:0] er[4];
      logic [4:0]  ef[4];
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
      sv = '{1'b0, 1'b1, 1'b0, 1'b0};
      ev = '{10'd254, 10'd300, 10'd255, 10'd254};
      mv = '{24'hFFFFFF, 24'h800000, 24'h800000, 24'h800000};
      gv = '{3'b100, 3'b000, 3'b000, 3'b000};
`ifdef FP_PACK_ROUND_EN
      er = '{32'h7F800000, 32'hFF800000, 32'h7F800000, 32'h7F000000};
      ef = '{5'h15, 5'h15, 5'h15, 5'h00};
`else
      er = '{32'h7F7FFFFF, 32'hFF800000, 32'h7F800000, 32'h7F000000};
      ef = '{5'h01, 5'h15, 5'h15, 5'h00};
`endif
      for (int i = 0; i < 4; i++) begin
         drive_single(sv[i], ev[i], mv[i], gv[i], 1'b0, res, flg, lat);
         $display("txn overflow_%0d: result=%h flags=%h", i, res, flg);
         checks++;
         if (res !== er[i] || flg !== ef[i]) begin
            errors++;
            $display("FAIL overflow_%0d: got %h/%h expected %h/%h", i, res, flg, er[i], ef[i]);
         end
      end
   endtask

   task automatic test_underflow();
      logic        sv[5];
      logic [9:0]  ev[5];
      logic [23:0] mv[5];
      logic [31:0] er[5];
      logic [4:0]  ef[5];
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
      sv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      ev = '{10'd0, 10'h3FB, 10'd127, 10'd1, 10'd127};
      mv = '{24'h800000, 24'h800000, 24'h000000, 24'h800000, 24'h000000};
      er = '{32'h00000000, 32'h80000000, 32'h00000000, 32'h00800000, 32'h80000000};
      ef = '{5'h0B, 5'h0B, 5'h08, 5'h00, 5'h08};
      for (int i = 0; i < 5; i++) begin
         drive_single(sv[i], ev[i], mv[i], 3'b000, 1'b0, res, flg, lat);
         $display("txn underflow_%0d: result=%h flags=%h", i, res, flg);
         checks++;
         if (res !== er[i] || flg !== ef[i]) begin
            errors++;
            $display("FAIL underflow_%0d: got %h/%h expected %h/%h", i, res, flg, er[i], ef[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_b[4];
      int          nin;
      int          nout;
      logic        ir;
      exp_b = '{32'h3F800000, 32'h40000000, 32'h40800000, 32'h41000000};
      nin = 0;
      nout = 0;
      for (int c = 0; c < 24 && nout < 4; c++) begin
         out_ready = (c >= 6);
         #1;
         ir = in_ready;
         if (c == 2) begin
            checks++;
            if (ir !== 1'b0 || nin != 2) begin
               errors++;
               $display("FAIL bp_in_ready_drop: got in_ready=%b captured=%0d expected in_ready=0 captured=2", ir, nin);
            end
         end
         if (c >= 2 && c < 6) begin
            checks++;
            if (out_valid !== 1'b1 || fp_result !== exp_b[0]) begin
               errors++;
               $display("FAIL bp_stall_hold_c%0d: got valid=%b result=%h expected 1/%h", c, out_valid, fp_result, exp_b[0]);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            $display("txn bp_out_%0d: cycle=%0d result=%h", nout, c, fp_result);
            checks++;
            if (fp_result !== exp_b[nout] || c != 6 + nout) begin
               errors++;
               $display("FAIL bp_out_%0d: got %h at cycle %0d expected %h at cycle %0d", nout, fp_result, c, exp_b[nout], 6 + nout);
            end
            nout++;
         end
         if (nin < 4) begin
            in_valid = 1'b1;
            in_sign = 1'b0;
            in_exponent = 10'(127 + nin);
            in_significand = {24'h800000, 3'b000};
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clock); #1;
         if (in_valid && ir) nin++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (nout != 4) begin
         errors++;
         $display("FAIL bp_count: got %0d results expected 4", nout);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_sticky();
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
      flags_clear = 1'b1;
      @(posedge clock); #1;
      flags_clear = 1'b0;
      $display("txn sticky_clear: sticky=%h", sticky_flags);
      checks++;
      if (sticky_flags !== 5'h00) begin
         errors++;
         $display("FAIL sticky_clear: got %h expected 00", sticky_flags);
      end
      drive_single(1'b0, 10'd300, 24'h800000, 3'b000, 1'b0, res, flg, lat);
      drive_single(1'b0, 10'd127, 24'h800000, 3'b000, 1'b0, res, flg, lat);
      $display("txn sticky_accum: result=%h sticky=%h", res, sticky_flags);
      checks++;
      if (sticky_flags !== 5'h15) begin
         errors++;
         $display("FAIL sticky_accum: got %h expected 15", sticky_flags);
      end
      drive_single(1'b0, 10'd127, 24'h800000, 3'b001, 1'b1, res, flg, lat);
      $display("txn sticky_clear_xfer: result=%h flags=%h sticky=%h", res, flg, sticky_flags);
      checks++;
      if (res !== 32'h3F800000 || flg !== 5'h01) begin
         errors++;
         $display("FAIL sticky_inexact_res: got %h/%h expected 3f800000/01", res, flg);
      end
      checks++;
      if (sticky_flags !== 5'h01) begin
         errors++;
         $display("FAIL sticky_clear_xfer: got %h expected 01", sticky_flags);
      end
   endtask

   task automatic test_reset_midflight();
      int stale;
      out_ready = 1'b1;
      in_sign = 1'b0;
      in_significand = {24'h800000, 3'b000};
      in_exponent = 10'd127;
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_exponent = 10'd128;
      @(posedge clock); #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL midflight_pre: got out_valid=%b expected 1", out_valid);
      end
      resetn = 1'b0;
      #1;
      $display("txn midflight_reset: valid=%b sticky=%h result=%h", out_valid, sticky_flags, fp_result);
      checks++;
      if (out_valid !== 1'b0 || sticky_flags !== 5'h00 || fp_result !== 32'h0 || flags !== 5'h0) begin
         errors++;
         $display("FAIL midflight_reset: got valid=%b sticky=%h result=%h flags=%h expected 0/00/00000000/00",
                  out_valid, sticky_flags, fp_result, flags);
      end
      @(posedge clock); #3;
      resetn = 1'b1;
      out_ready = 1'b1;
      stale = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clock); #1;
         if (out_valid !== 1'b0) stale++;
      end
      checks++;
      if (stale != 0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midflight_stale: got %0d stale cycles in_ready=%b expected 0/1", stale, in_ready);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_exact();
      test_rounding();
      test_overflow();
      test_underflow();
      test_backpressure();
      test_sticky();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
